// File: rtl/reg_bus_master.sv
// Register-bus initiator: takes one host command at a time, runs a single bus
// read or write (or rejects it), and returns exactly one response per command.
module reg_bus_master #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int RO_TOP   = 1,
    parameter int MAX_ADDR = 81
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              bus_en,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_r_wn,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    // state | meaning
    // IDLE  | cmd_ready high, waiting for a host command
    // ISSUE | bus_en strobe cycle for an accepted legal command
    // WAIT  | read latency countdown, rdata captured at terminal count
    // RESP  | response presented, held until the host accepts it
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [ADDR_W-1:0] RO_TOP_A   = ADDR_W'(RO_TOP);
    localparam logic [ADDR_W-1:0] MAX_ADDR_A = ADDR_W'(MAX_ADDR);
    // Counter runs RD_LAT-1 .. 0 so the capture edge closes cycle T+RD_LAT.
    localparam logic [2:0]        LAT_LOAD   = 3'(RD_LAT - 1);

    state_t     state;
    logic       op_write;
    logic [2:0] lat_cnt;
    logic       cmd_err;

    assign cmd_err = (cmd_write && (cmd_addr <= RO_TOP_A)) || (cmd_addr > MAX_ADDR_A);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_write  <= 1'b0;
            lat_cnt   <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            bus_en    <= 1'b0;
            bus_addr  <= '0;
            bus_r_wn  <= 1'b1;
            bus_wdata <= '0;
        end else begin
            bus_en   <= 1'b0;
            bus_r_wn <= 1'b1;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        op_write  <= cmd_write;
                        if (cmd_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end else begin
                            bus_en    <= 1'b1;
                            bus_addr  <= cmd_addr;
                            bus_r_wn  <= ~cmd_write;
                            bus_wdata <= cmd_wdata;
                            state     <= ISSUE;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (op_write) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= LAT_LOAD;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= bus_rdata;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master: one instance at RD_LAT=1, one at RD_LAT=3,
// each with a small register-file model that drives valid rdata only in cycle T+RD_LAT.
module tb_reg_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
    logic [6:0]  cmd_addr  = '0;
    logic [31:0] cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_err, bus_en, bus_r_wn;
    logic [31:0] rsp_rdata, bus_wdata;
    logic [31:0] bus_rdata = 32'hDEAD_BEEF;
    logic [6:0]  bus_addr;

    logic        cmd_valid_3 = 1'b0, cmd_write_3 = 1'b0, rsp_ready_3 = 1'b1;
    logic [6:0]  cmd_addr_3  = '0;
    logic [31:0] cmd_wdata_3 = '0;
    logic        cmd_ready_3, rsp_valid_3, rsp_err_3, bus_en_3, bus_r_wn_3;
    logic [31:0] rsp_rdata_3, bus_wdata_3;
    logic [31:0] bus_rdata_3 = 32'hDEAD_BEEF;
    logic [6:0]  bus_addr_3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_bus_master #(.RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_en(bus_en), .bus_addr(bus_addr), .bus_r_wn(bus_r_wn),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    reg_bus_master #(.RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3), .cmd_write(cmd_write_3),
        .cmd_addr(cmd_addr_3), .cmd_wdata(cmd_wdata_3),
        .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_rdata(rsp_rdata_3), .rsp_err(rsp_err_3),
        .bus_en(bus_en_3), .bus_addr(bus_addr_3), .bus_r_wn(bus_r_wn_3),
        .bus_wdata(bus_wdata_3), .bus_rdata(bus_rdata_3)
    );

    // Register file model: register a reads back as {a, 8'h00}.
    function automatic logic [31:0] reg_val(input logic [6:0] a);
        return {17'h0, a, 8'h00};
    endfunction

    int         age1 = 100, age3 = 100;
    int         en_cnt1 = 0, en_cnt3 = 0;
    logic [6:0] pa1 = '0, pa3 = '0;

    always @(negedge clk) begin
        if (bus_en) begin
            age1 = 0; pa1 = bus_addr; en_cnt1++;
        end else if (age1 < 100) age1++;
        bus_rdata = (age1 == 1) ? reg_val(pa1) : 32'hDEAD_BEEF;
        if (bus_en_3) begin
            age3 = 0; pa3 = bus_addr_3; en_cnt3++;
        end else if (age3 < 100) age3++;
        bus_rdata_3 = (age3 == 3) ? reg_val(pa3) : 32'hDEAD_BEEF;
    end

    // Presents a command at a negedge and returns at the negedge of cycle C+1.
    task automatic send(input logic w, input logic [6:0] a, input logic [31:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        while (!cmd_ready && n < 20) begin
            @(negedge clk); n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready_timeout cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, bus_en, bus_r_wn} !== 5'b00001 ||
            rsp_rdata !== 32'h0 || bus_addr !== 7'h0 || bus_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_values rdy=%b rv=%b err=%b en=%b rwn=%b rdata=%h addr=%h wdata=%h required 0 0 0 0 1 0 0 0",
                     cmd_ready, rsp_valid, rsp_err, bus_en, bus_r_wn, rsp_rdata, bus_addr, bus_wdata);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || cmd_ready_3 !== 1'b0) begin
            failures++;
            $display("FAIL reset_held_ready cmd_ready=%b/%b required 0/0", cmd_ready, cmd_ready_3);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || cmd_ready_3 !== 1'b1 || bus_en !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release rdy=%b rdy3=%b en=%b rv=%b required 1 1 0 0",
                     cmd_ready, cmd_ready_3, bus_en, rsp_valid);
        end
    endtask

    task automatic test_write();
        int base;
        rsp_ready = 1'b1;
        base = en_cnt1;
        send(1'b1, 7'h02, 32'hA5A5_0001);
        checks++;
        if (bus_en !== 1'b1 || bus_r_wn !== 1'b0 || bus_addr !== 7'h02 ||
            bus_wdata !== 32'hA5A5_0001 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL write_issue en=%b rwn=%b addr=%h wdata=%h rv=%b required 1 0 02 a5a50001 0",
                     bus_en, bus_r_wn, bus_addr, bus_wdata, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (bus_en !== 1'b0 || bus_r_wn !== 1'b1 || rsp_valid !== 1'b1 || rsp_err !== 1'b0 ||
            rsp_rdata !== 32'h0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL write_resp en=%b rwn=%b rv=%b err=%b rdata=%h rdy=%b required 0 1 1 0 0 0",
                     bus_en, bus_r_wn, rsp_valid, rsp_err, rsp_rdata, cmd_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || en_cnt1 - base !== 1) begin
            failures++;
            $display("FAIL write_done rv=%b rdy=%b en_cycles=%0d required 0 1 1",
                     rsp_valid, cmd_ready, en_cnt1 - base);
        end
        @(negedge clk);
    endtask

    task automatic test_read_lat1();
        int base;
        base = en_cnt1;
        send(1'b0, 7'h01, 32'h0);
        checks++;
        if (bus_en !== 1'b1 || bus_r_wn !== 1'b1 || bus_addr !== 7'h01) begin
            failures++;
            $display("FAIL read1_issue en=%b rwn=%b addr=%h required 1 1 01", bus_en, bus_r_wn, bus_addr);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || bus_en !== 1'b0) begin
            failures++;
            $display("FAIL read1_wait rv=%b en=%b required 0 0", rsp_valid, bus_en);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_0100 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL read1_resp rv=%b rdata=%h err=%b required 1 00000100 0", rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || en_cnt1 - base !== 1) begin
            failures++;
            $display("FAIL read1_done rv=%b rdy=%b en_cycles=%0d required 0 1 1", rsp_valid, cmd_ready, en_cnt1 - base);
        end
        @(negedge clk);
    endtask

    task automatic test_read_lat3();
        int base;
        logic early;
        base = en_cnt3;
        early = 1'b0;
        cmd_valid_3 = 1'b1; cmd_write_3 = 1'b0; cmd_addr_3 = 7'h01; cmd_wdata_3 = 32'h0;
        checks++;
        if (cmd_ready_3 !== 1'b1) begin
            failures++;
            $display("FAIL read3_ready cmd_ready=%b required 1", cmd_ready_3);
        end
        @(negedge clk);
        cmd_valid_3 = 1'b0;
        checks++;
        if (bus_en_3 !== 1'b1 || bus_r_wn_3 !== 1'b1 || bus_addr_3 !== 7'h01) begin
            failures++;
            $display("FAIL read3_issue en=%b rwn=%b addr=%h required 1 1 01", bus_en_3, bus_r_wn_3, bus_addr_3);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid_3 !== 1'b0 || bus_en_3 !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            failures++;
            $display("FAIL read3_wait early response or extra strobe seen, required none in C+2..C+4");
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid_3 !== 1'b1 || rsp_rdata_3 !== 32'h0000_0100 || rsp_err_3 !== 1'b0 || en_cnt3 - base !== 1) begin
            failures++;
            $display("FAIL read3_resp rv=%b rdata=%h err=%b en_cycles=%0d required 1 00000100 0 1",
                     rsp_valid_3, rsp_rdata_3, rsp_err_3, en_cnt3 - base);
        end
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic       ew [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [6:0] ea [5] = '{7'h00, 7'h01, 7'h7F, 7'h52, 7'h52};
        int base;
        base = en_cnt1;
        for (int i = 0; i < 5; i++) begin
            send(ew[i], ea[i], 32'h1111_2222);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || bus_en !== 1'b0) begin
                failures++;
                $display("FAIL err_resp_%0d rv=%b err=%b rdata=%h en=%b required 1 1 0 0",
                         i, rsp_valid, rsp_err, rsp_rdata, bus_en);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (en_cnt1 - base !== 0) begin
            failures++;
            $display("FAIL err_no_strobe en_cycles=%0d required 0", en_cnt1 - base);
        end
        send(1'b0, 7'h51, 32'h0);
        checks++;
        if (bus_en !== 1'b1 || bus_addr !== 7'h51) begin
            failures++;
            $display("FAIL max_addr_issue en=%b addr=%h required 1 51", bus_en, bus_addr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0000_5100) begin
            failures++;
            $display("FAIL max_addr_resp rv=%b err=%b rdata=%h required 1 0 00005100", rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic bad;
        bad = 1'b0;
        rsp_ready = 1'b0;
        send(1'b0, 7'h03, 32'h0);
        repeat (2) @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h04; cmd_wdata = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_0300 || rsp_err !== 1'b0 ||
                cmd_ready !== 1'b0 || bus_en !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL bp_hold rv=%b rdata=%h err=%b rdy=%b required 1 00000300 0 0 for 5 cycles",
                     rsp_valid, rsp_rdata, rsp_err, cmd_ready);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release rv=%b rdy=%b required 0 1", rsp_valid, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (bus_en !== 1'b1 || bus_r_wn !== 1'b0 || bus_addr !== 7'h04 ||
            bus_wdata !== 32'h1234_5678 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_queued_issue en=%b rwn=%b addr=%h wdata=%h rdy=%b required 1 0 04 12345678 0",
                     bus_en, bus_r_wn, bus_addr, bus_wdata, cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL bp_queued_resp rv=%b err=%b required 1 0", rsp_valid, rsp_err);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int strobes = 0;
        int last = -1;
        logic bad = 1'b0;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h10; cmd_wdata = 32'hB000_0010;
        for (int cyc = 0; cyc < 30 && strobes < 4; cyc++) begin
            @(negedge clk);
            if (bus_en === 1'b1) begin
                if (bus_addr !== 7'(7'h10 + strobes) || (last >= 0 && cyc - last != 3)) bad = 1'b1;
                last = cyc;
                strobes++;
                cmd_addr  = 7'(7'h10 + strobes);
                cmd_wdata = 32'hB000_0010 + 32'(strobes);
                if (strobes == 4) cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (bad || strobes != 4) begin
            failures++;
            $display("FAIL b2b_period strobes=%0d bad=%b required 4 strobes every 3 cycles", strobes, bad);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic spurious;
        spurious = 1'b0;
        rsp_ready = 1'b1;
        send(1'b0, 7'h07, 32'h0000_0077);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, bus_en, bus_r_wn} !== 5'b00001 ||
            rsp_rdata !== 32'h0 || bus_addr !== 7'h0 || bus_wdata !== 32'h0) begin
            failures++;
            $display("FAIL midrst_async rdy=%b rv=%b err=%b en=%b rwn=%b rdata=%h addr=%h wdata=%h required 0 0 0 0 1 0 0 0",
                     cmd_ready, rsp_valid, rsp_err, bus_en, bus_r_wn, rsp_rdata, bus_addr, bus_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            failures++;
            $display("FAIL midrst_no_resp rv=%b rdy=%b required 0 1 for 6 cycles", rsp_valid, cmd_ready);
        end
        send(1'b0, 7'h02, 32'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0000_0200) begin
            failures++;
            $display("FAIL midrst_next_read rv=%b err=%b rdata=%h required 1 0 00000200", rsp_valid, rsp_err, rsp_rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read_lat1();
        test_read_lat3();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
